// File: rtl/fir_pkg.sv
// Shared width and output-scaling helpers for the transposed-form FIR filter.
package fir_pkg;

    // Partial-sum width that holds the sum of n full-precision d x t products without overflow.
    function automatic int unsigned acc_width(input int unsigned d, input int unsigned t,
                                              input int unsigned n);
        return d + t + int'($clog2(n));
    endfunction

    // Arithmetic right shift (floor rounding), then clamp to a signed dw-bit range.
    function automatic longint sat_shift(input longint value, input int unsigned shift,
                                         input int unsigned dw);
        longint shifted;
        longint max_v;
        longint min_v;
        shifted = value >>> shift;
        max_v   = (longint'(1) <<< (dw - 1)) - longint'(1);
        min_v   = -(longint'(1) <<< (dw - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fir_tap_stage.sv
// One tap of the transposed FIR: registers coeff*in plus the partial sum from the next tap.
module fir_tap_stage #(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int ACC_WIDTH       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_WIDTH-1:0]      in,
    input  logic signed [TAP_COEFF_WIDTH-1:0] coeff,
    input  logic signed [ACC_WIDTH-1:0]       sum_in,
    output logic signed [ACC_WIDTH-1:0]       sum_out
);

    localparam int ProdWidth = DATA_WIDTH + TAP_COEFF_WIDTH;

    logic signed [ProdWidth-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] r_sum;

    // Full-precision product; both operands sign-extended so -2^(D-1) * -2^(T-1) is exact.
    assign w_prod = ProdWidth'(coeff) * ProdWidth'(in);

    // Partial-sum register; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= ACC_WIDTH'(w_prod) + sum_in;
        end
    end

    assign sum_out = r_sum;

endmodule

// File: rtl/fir_transpose_nom.sv
// Transposed-form FIR with runtime coefficients: one sample in and one sample out per clock.
module fir_transpose_nom
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_WIDTH-1:0]      in,
    output logic signed [DATA_WIDTH-1:0]      out,
    input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS-1:0]
);

    localparam int AccWidth = int'(acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS));

    // w_z[k] is the registered partial sum of tap k; w_z[0] holds y[n].
    logic signed [AccWidth-1:0] w_z [NUM_TAPS];

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        if (k == NUM_TAPS - 1) begin : g_last
            fir_tap_stage #(
                .DATA_WIDTH      (DATA_WIDTH),
                .TAP_COEFF_WIDTH (TAP_COEFF_WIDTH),
                .ACC_WIDTH       (AccWidth)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .in      (in),
                .coeff   (tap_coeffs[k]),
                .sum_in  ('0),
                .sum_out (w_z[k])
            );
        end else begin : g_mid
            fir_tap_stage #(
                .DATA_WIDTH      (DATA_WIDTH),
                .TAP_COEFF_WIDTH (TAP_COEFF_WIDTH),
                .ACC_WIDTH       (AccWidth)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .in      (in),
                .coeff   (tap_coeffs[k]),
                .sum_in  (w_z[k+1]),
                .sum_out (w_z[k])
            );
        end
    end

    // Output depends only on register w_z[0]: drop the Q1.(T-1) fraction, then saturate.
    assign out = DATA_WIDTH'(sat_shift(longint'(w_z[0]), TAP_COEFF_WIDTH - 1, DATA_WIDTH));

endmodule

// File: tb/tb_fir_transpose_nom.sv
// Directed self-checking bench for fir_transpose_nom at D=5, T=5, N=50.
module tb_fir_transpose_nom;

    localparam int D = 5;
    localparam int T = 5;
    localparam int N = 50;

    logic                  clk;
    logic                  rst;
    logic signed [D-1:0]   din;
    logic signed [D-1:0]   dout;
    logic signed [T-1:0]   coeffs [N-1:0];

    int x_hist [N];
    int n_checks;
    int n_fail;

    fir_transpose_nom #(
        .DATA_WIDTH      (D),
        .TAP_COEFF_WIDTH (T),
        .NUM_TAPS        (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .out        (dout),
        .tap_coeffs (coeffs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct-form reference: floor(sum c_k x[n-k] / 16), saturated to 5 bits.
    function automatic int model_out();
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(coeffs[k]) * x_hist[k];
        acc = acc >>> (T - 1);
        if (acc > 15) acc = 15;
        if (acc < -16) acc = -16;
        return acc;
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < N; k++) x_hist[k] = 0;
    endtask

    task automatic set_default_coeffs();
        for (int k = 0; k < N; k++) coeffs[k] = (k < 4) ? 5'sd3 : 5'sd0;
    endtask

    // One rising edge; records the sample the DUT took, then samples outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        for (int k = N - 1; k > 0; k--) x_hist[k] = x_hist[k-1];
        x_hist[0] = int'(din);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = '0;
        clear_hist();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            din = (i % 2 == 0) ? 5'sd15 : -5'sd16;
            #5;
            n_checks++;
            if (dout !== 5'sd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, dout);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        din = 5'sd15;
        clear_hist();
        step();
        n_checks++;
        if (dout !== 5'sd2) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %0d expected 2", dout);
        end
    endtask

    task automatic test_impulse();
        int exp_v [6] = '{2, 2, 2, 2, 0, 0};
        do_reset();
        din = 5'sd15;
        for (int i = 0; i < 6; i++) begin
            step();
            din = '0;
            n_checks++;
            if (dout !== D'(exp_v[i])) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got %0d expected %0d", i, dout, exp_v[i]);
            end
        end
    endtask

    task automatic test_step(input logic signed [D-1:0] level, input int e0, input int e1,
                             input int e2, input int e3);
        int exp_v [7];
        exp_v = '{e0, e1, e2, e3, e3, e3, e3};
        do_reset();
        din = level;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (dout !== D'(exp_v[i])) begin
                n_fail++;
                $display("FAIL step(%0d)[%0d]: got %0d expected %0d", level, i, dout, exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation(input logic signed [D-1:0] level, input int clamp);
        int exp;
        for (int k = 0; k < N; k++) coeffs[k] = 5'sd15;
        do_reset();
        din = level;
        for (int i = 0; i < 60; i++) begin
            step();
            exp = model_out();
            n_checks++;
            if (dout !== D'(exp)) begin
                n_fail++;
                $display("FAIL sat(%0d)[%0d]: got %0d expected %0d", level, i, dout, exp);
            end
        end
        n_checks++;
        if (dout !== D'(clamp)) begin
            n_fail++;
            $display("FAIL sat_final(%0d): got %0d expected %0d", level, dout, clamp);
        end
        set_default_coeffs();
    endtask

    task automatic test_ramp();
        int exp;
        do_reset();
        din = -5'sd1;
        for (int i = 0; i < 107; i++) begin
            step();
            exp = model_out();
            n_checks++;
            if (dout !== D'(exp)) begin
                n_fail++;
                $display("FAIL ramp[%0d]: got %0d expected %0d", i, dout, exp);
            end
            din = din + 5'sd1;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        din = -5'sd1;
        for (int i = 0; i < 10; i++) begin
            step();
            din = din + 5'sd1;
        end
        // x history is 8,7,6,5 -> 78/16 = 4
        n_checks++;
        if (dout !== 5'sd4) begin
            n_fail++;
            $display("FAIL async_pre: got %0d expected 4", dout);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dout !== 5'sd0) begin
            n_fail++;
            $display("FAIL async_reset: got %0d expected 0", dout);
        end
        @(negedge clk);
        rst = 1'b0;
        din = 5'sd15;
        clear_hist();
        step();
        n_checks++;
        if (dout !== 5'sd2) begin
            n_fail++;
            $display("FAIL async_release: got %0d expected 2", dout);
        end
    endtask

    task automatic test_coeff_change();
        int exp_c0 [3] = '{10, 10, 10};
        int exp_c3 [5] = '{7, 7, 7, 10, 10};
        do_reset();
        din = 5'sd10;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (dout !== 5'sd7) begin
            n_fail++;
            $display("FAIL coeff_steady: got %0d expected 7", dout);
        end
        // Tap 0 is always formed fresh: 80 + 90 = 170 -> 10
        coeffs[0] = 5'sd8;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dout !== D'(exp_c0[i])) begin
                n_fail++;
                $display("FAIL coeff_c0[%0d]: got %0d expected %0d", i, dout, exp_c0[i]);
            end
        end
        // Tap 3 change must wait for in-flight sums to drain (3 edges) before showing
        set_default_coeffs();
        do_reset();
        din = 5'sd10;
        for (int i = 0; i < 6; i++) step();
        coeffs[3] = 5'sd8;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (dout !== D'(exp_c3[i])) begin
                n_fail++;
                $display("FAIL coeff_c3[%0d]: got %0d expected %0d", i, dout, exp_c3[i]);
            end
        end
        set_default_coeffs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        din      = '0;
        set_default_coeffs();
        clear_hist();

        test_reset();
        test_impulse();
        test_step(5'sd15, 2, 5, 8, 11);
        test_step(-5'sd16, -3, -6, -9, -12);
        test_saturation(5'sd15, 15);
        test_saturation(-5'sd16, -16);
        test_ramp();
        test_async_reset();
        test_coeff_change();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
